// File: rtl/fp_pkg.sv
// Shared constants and types for the FP multiplier writeback stage.
package fp_pkg;

  localparam int unsigned FLG_NV  = 4;
  localparam int unsigned FLG_OF  = 3;
  localparam int unsigned FLG_UF  = 2;
  localparam int unsigned FLG_RSV = 1;
  localparam int unsigned FLG_NX  = 0;

  localparam logic [1:0] LANES_FULL = 2'b11;
  localparam logic [1:0] LANES_LO   = 2'b01;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [15:0] QNAN16 = 16'h7E00;

  typedef struct packed {
    logic [1:0]  lanes;
    logic [31:0] data;
  } wb_word_t;

  function automatic logic [31:0] pack_halves(input logic [15:0] hi, input logic [15:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/fp_wb_stage_if.sv
// Result-in / word-out handshake bundle of the writeback stage.
interface fp_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_flags;
  logic        in_mode_fp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_lanes;

  modport master (
    output in_valid, in_result, in_flags, in_mode_fp, out_ready,
    input  in_ready, out_valid, out_data, out_lanes
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_mode_fp, out_ready,
    output in_ready, out_valid, out_data, out_lanes
  );
endinterface

// File: rtl/fp_wb_fifo.sv
// Circular DEPTH x WIDTH FIFO; head data reads as zero when empty.
module fp_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // A full FIFO refuses pushes even when a pop frees a slot the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/fp_wb_stage.sv
// FP multiplier writeback: fp16 pairing, output FIFO and sticky fflags.
// Optional FP_FLAG_IRQ_EN adds irq_mask/irq for a registered flag interrupt.
module fp_wb_stage
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fp_wb_stage_if.slave           bus,
  input  logic                   flush_half,
  input  logic                   fflags_clr,
  output logic [$clog2(DEPTH):0] count,
  output logic [4:0]             fflags
`ifdef FP_FLAG_IRQ_EN
  ,
  input  logic [4:0]             irq_mask,
  output logic                   irq
`endif
);

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_accept;
  logic        w_in_ready;
  wb_word_t    w_wdata;
  wb_word_t    w_rdata;
  logic [15:0] w_pend_next;
  logic        w_pend_v_next;
  logic [4:0]  w_fflags_next;

  logic [15:0] r_pend;
  logic        r_pend_v;
  logic [4:0]  r_fflags;

  // fp16 with no pending half only updates the pend register, so it may enter when full.
  assign w_in_ready = !(r_pend_v && bus.in_mode_fp) &&
                      (!w_full || (!bus.in_mode_fp && !r_pend_v));
  assign w_accept   = bus.in_valid && w_in_ready;

  always_comb begin
    w_push        = 1'b0;
    w_wdata       = '0;
    w_pend_next   = r_pend;
    w_pend_v_next = r_pend_v;
    if (w_accept) begin
      if (bus.in_mode_fp) begin
        w_push  = 1'b1;
        w_wdata = '{lanes: LANES_FULL, data: bus.in_result};
      end else if (r_pend_v) begin
        w_push        = 1'b1;
        w_wdata       = '{lanes: LANES_FULL, data: pack_halves(bus.in_result[15:0], r_pend)};
        w_pend_v_next = 1'b0;
      end else begin
        w_pend_next   = bus.in_result[15:0];
        w_pend_v_next = 1'b1;
      end
    end else if (r_pend_v && !w_full && ((bus.in_valid && bus.in_mode_fp) || flush_half)) begin
      // Drain the orphaned half so a waiting fp32 result can follow it.
      w_push        = 1'b1;
      w_wdata       = '{lanes: LANES_LO, data: pack_halves(16'h0, r_pend)};
      w_pend_v_next = 1'b0;
    end
  end

  always_comb begin
    if (fflags_clr) begin
      w_fflags_next = w_accept ? bus.in_flags : 5'b0;
    end else begin
      w_fflags_next = w_accept ? (r_fflags | bus.in_flags) : r_fflags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_fflags <= '0;
    end else begin
      r_pend   <= w_pend_next;
      r_pend_v <= w_pend_v_next;
      r_fflags <= w_fflags_next;
    end
  end

  assign w_pop = !w_empty && bus.out_ready;

  fp_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_word_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_rdata.data;
  assign bus.out_lanes = w_rdata.lanes;
  assign fflags        = r_fflags;

`ifdef FP_FLAG_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= |(w_fflags_next & irq_mask);
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_fp_wb_stage.sv
// Scoreboard bench for fp_wb_stage: expected words queued at drive time, checked on pop.
module tb_fp_wb_stage;
  import fp_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_half = 1'b0;
  logic       fflags_clr = 1'b0;
  logic [2:0] count;
  logic [4:0] fflags;
`ifdef FP_FLAG_IRQ_EN
  logic [4:0] irq_mask = 5'h1f;
  logic       irq;
`endif

  always #5 clk = ~clk;

  fp_wb_stage_if bus ();

  fp_wb_stage #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush_half (flush_half),
    .fflags_clr (fflags_clr),
    .count      (count),
    .fflags     (fflags)
`ifdef FP_FLAG_IRQ_EN
    ,
    .irq_mask   (irq_mask),
    .irq        (irq)
`endif
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [33:0] sb_q[$];
  logic        tb_pend_v = 1'b0;
  logic [15:0] tb_pend = '0;
  logic [4:0]  tb_fflags = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model the packing when stimulus is driven; pushes land in the order the DUT emits them.
  task automatic send(input logic fp32, input logic [31:0] res, input logic [4:0] flg,
                      output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    if (fp32) begin
      if (tb_pend_v) begin
        sb_q.push_back({LANES_LO, 16'h0, tb_pend});
        tb_pend_v = 1'b0;
      end
      sb_q.push_back({LANES_FULL, res});
    end else if (tb_pend_v) begin
      sb_q.push_back({LANES_FULL, res[15:0], tb_pend});
      tb_pend_v = 1'b0;
    end else begin
      tb_pend   = res[15:0];
      tb_pend_v = 1'b1;
    end
    bus.in_valid   = 1'b1;
    bus.in_mode_fp = fp32;
    bus.in_result  = res;
    bus.in_flags   = flg;
    for (int c = 0; c < 64 && !acc; c++) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 64'(acc), 64'(1));
    else tb_fflags = fflags_clr ? flg : (tb_fflags | flg);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        check_eq("sb_has_entry", 64'(sb_q.size() != 0), 64'(1));
        if (sb_q.size() != 0) check_eq("out_word", 64'({bus.out_lanes, bus.out_data}),
                                       64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] fp32_vals [3];
  logic [31:0] bp_vals [5];
  int          st;
  int          st5;

  initial begin
    fp32_vals = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    bp_vals   = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    bus.in_valid   = 1'b0;
    bus.in_result  = '0;
    bus.in_flags   = '0;
    bus.in_mode_fp = 1'b1;
    bus.out_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_count", 64'(count), 64'(0));
    check_eq("rst_out_data", 64'(bus.out_data), 64'(0));
    check_eq("rst_out_lanes", 64'(bus.out_lanes), 64'(0));
    check_eq("rst_fflags", 64'(fflags), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", 64'(bus.in_ready), 64'(1));

    // fp32 stream, one cycle latency
    foreach (fp32_vals[i]) begin
      send(1'b1, fp32_vals[i], 5'b0, st);
      check_eq("fp32_stall", 64'(st), 64'(0));
      check_eq("fp32_lat_valid", 64'(bus.out_valid), 64'(1));
      check_eq("fp32_lat_data", 64'(bus.out_data), 64'(fp32_vals[i]));
      check_eq("fp32_count", 64'(count), 64'(1));
    end
    repeat (2) @(posedge clk);
    #1;

    // fp16 pairing
    send(1'b0, 32'h0000_3C00, 5'b0, st);
    repeat (2) @(posedge clk);
    #1;
    check_eq("half_no_out", 64'(bus.out_valid), 64'(0));
    send(1'b0, 32'h0000_4000, 5'b0, st);
    check_eq("pair_data", 64'(bus.out_data), 64'(32'h4000_3C00));
    check_eq("pair_lanes", 64'(bus.out_lanes), 64'(LANES_FULL));

    // pending half then fp32
    send(1'b0, 32'h0000_3C00, 5'b0, st);
    send(1'b1, 32'h7F80_0000, 5'b0, st);
    check_eq("pend_fp32_stall", 64'(st), 64'(1));

    // explicit flush of a lone half
    send(1'b0, 32'h0000_1234, 5'b0, st);
    sb_q.push_back({LANES_LO, 16'h0, tb_pend});
    tb_pend_v  = 1'b0;
    flush_half = 1'b1;
    @(posedge clk);
    #1;
    flush_half = 1'b0;
    check_eq("flush_lanes", 64'(bus.out_lanes), 64'(LANES_LO));
    check_eq("flush_data", 64'(bus.out_data), 64'(32'h0000_1234));
    repeat (3) @(posedge clk);
    #1;

    // backpressure and pointer wrap
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, bp_vals[i], 5'b0, st);
      check_eq("bp_fill_stall", 64'(st), 64'(0));
    end
    check_eq("bp_count_full", 64'(count), 64'(DEPTH));
    bus.in_mode_fp = 1'b1;
    #1;
    check_eq("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
    fork
      send(1'b1, bp_vals[4], 5'b0, st5);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    check_eq("bp_5th_stalled", 64'(st5 >= 1), 64'(1));
    repeat (8) @(posedge clk);
    #1;
    check_eq("bp_drained", 64'(count), 64'(0));

    // sticky flags
    send(1'b1, 32'h0, 5'b00001, st);
    send(1'b1, 32'h0, 5'b01000, st);
    send(1'b1, 32'h0, 5'b10000, st);
    check_eq("fflags_acc", 64'(fflags), 64'(5'b11001));
    check_eq("fflags_model", 64'(fflags), 64'(tb_fflags));
`ifdef FP_FLAG_IRQ_EN
    check_eq("irq_set", 64'(irq), 64'(|(tb_fflags & irq_mask)));
`endif
    fflags_clr = 1'b1;
    send(1'b1, 32'h0, 5'b00100, st);
    fflags_clr = 1'b0;
    check_eq("fflags_clr_acc", 64'(fflags), 64'(5'b00100));
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    fflags_clr = 1'b0;
    tb_fflags  = '0;
    check_eq("fflags_clr_only", 64'(fflags), 64'(0));
`ifdef FP_FLAG_IRQ_EN
    check_eq("irq_clr", 64'(irq), 64'(0));
`endif
    repeat (3) @(posedge clk);
    #1;

    // async reset mid-stream
    bus.out_ready = 1'b0;
    send(1'b1, 32'hB000_0000, 5'b10000, st);
    send(1'b1, 32'hB111_1111, 5'b0, st);
    send(1'b0, 32'h0000_AAAA, 5'b0, st);
    check_eq("pre_rst_count", 64'(count), 64'(2));
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("mid_rst_count", 64'(count), 64'(0));
    check_eq("mid_rst_fflags", 64'(fflags), 64'(0));
    sb_q.delete();
    tb_pend_v = 1'b0;
    tb_fflags = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(1'b0, 32'h0000_5555, 5'b0, st);
    check_eq("post_rst_no_out", 64'(bus.out_valid), 64'(0));
    send(1'b0, 32'h0000_6666, 5'b0, st);
    check_eq("post_rst_pair", 64'({bus.out_lanes, bus.out_data}),
             64'({LANES_FULL, 32'h6666_5555}));

    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
